// File: rtl/hamming_serial_rx.sv
// hamming_serial_rx: strobe-fed serial Hamming receiver with single-error correction
// Ports: clk, rst (sync, active-high); d_in/strobe_in serial bit and async strobe;
// d_disp corrected data; valid decode pulse; err_corr/err_pos/err_unc status of last frame;
// busy partial frame pending; abort pulse when a partial frame times out.
// Define HAMMING_SECDED_EN to append an overall parity bit (SECDED, frame length N+1).
module hamming_serial_rx #(
  parameter int DATA_W      = 4,
  parameter int PAR_W       = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_in,
  input  logic              strobe_in,
  output logic [DATA_W-1:0] d_disp,
  output logic              valid,
  output logic              err_corr,
  output logic [PAR_W-1:0]  err_pos,
  output logic              err_unc,
  output logic              busy,
  output logic              abort
);
  localparam int N = DATA_W + PAR_W;
`ifdef HAMMING_SECDED_EN
  localparam int FL = N + 1;
`else
  localparam int FL = N;
`endif
  localparam int CW = $clog2(FL + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 2);
  typedef enum logic {COLLECT, DECODE} state_t;
  state_t state, state_nx;
  logic s1, s2, s3, d1, d2;
  logic [FL:1] cw;
  logic [CW-1:0] bit_cnt;
  logic [TW-1:0] tcnt;
  logic stb_edge, last_bit, tmo, dec, corr, unc;
  logic [PAR_W-1:0] syn;
  logic [N:1] fix;
  logic [DATA_W-1:0] dat;
  always_ff @(posedge clk)
    if (rst) {s1, s2, s3, d1, d2} <= '0;
    else {s1, s2, s3, d1, d2} <= {strobe_in, s1, s2, d_in, d1};
  assign stb_edge = s2 & ~s3;
  assign busy     = bit_cnt != '0;
  assign last_bit = 32'(bit_cnt) == FL - 1;
  // an edge in the timeout cycle keeps the frame alive
  assign tmo = TIMEOUT_CYC != 0 && busy && !stb_edge && 32'(tcnt) == TIMEOUT_CYC - 1;
  always_ff @(posedge clk)
    state <= rst ? COLLECT : state_nx;
  always_comb
    state_nx = (state == COLLECT && stb_edge && last_bit) ? DECODE : COLLECT;
  always_comb
    dec = state == DECODE;
  always_comb begin
    int k;
    syn = '0;
    for (int i = 1; i <= N; i++) if (cw[i]) syn ^= PAR_W'(i);
`ifdef HAMMING_SECDED_EN
    // overall parity mismatch marks a single error; syndrome 0 then blames the parity bit
    corr = (^cw) && 32'(syn) <= N;
    unc  = !corr && syn != '0;
`else
    corr = syn != '0 && 32'(syn) <= N;
    unc  = 32'(syn) > N;
`endif
    for (int i = 1; i <= N; i++) fix[i] = cw[i] ^ (corr && syn == PAR_W'(i));
    dat = '0;
    k = 0;
    for (int i = 1; i <= N; i++)
      if ((i & (i - 1)) != 0 && k < DATA_W) begin
        dat[k] = fix[i];
        k++;
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      cw       <= '0;
      bit_cnt  <= '0;
      tcnt     <= '0;
      d_disp   <= '0;
      valid    <= 1'b0;
      err_corr <= 1'b0;
      err_pos  <= '0;
      err_unc  <= 1'b0;
      abort    <= 1'b0;
    end else begin
      valid <= dec;
      abort <= tmo;
      // bit_cnt is already 0 in DECODE, so an edge there starts the next frame
      if (stb_edge) begin
        for (int i = 1; i <= FL; i++) if (CW'(i - 1) == bit_cnt) cw[i] <= d2;
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        tcnt    <= '0;
      end else if (tmo) begin
        bit_cnt <= '0;
        tcnt    <= '0;
      end else tcnt <= busy ? tcnt + 1'b1 : '0;
      if (dec) begin
        err_corr <= corr;
        err_pos  <= syn;
        err_unc  <= unc;
        if (!unc) d_disp <= dat;
      end
    end
endmodule

// File: tb/tb_hamming_serial_rx.sv
// tb_hamming_serial_rx: directed checks of the serial Hamming receiver
module tb_hamming_serial_rx;
  logic clk = 1'b0, rst = 1'b1, d_in = 1'b0, stb = 1'b0, d8 = 1'b0, stb8 = 1'b0;
  logic [3:0] d_disp;
  logic valid, err_corr, err_unc, busy, abort;
  logic [2:0] err_pos;
  logic [7:0] d_disp8;
  logic valid8, err_corr8, err_unc8, busy8, abort8;
  logic [3:0] err_pos8;
  int tests = 0, fails = 0, vcnt = 0, acnt = 0, vcnt8 = 0, v0, a0;
  always #5 clk = ~clk;
  hamming_serial_rx #(.DATA_W(4), .PAR_W(3), .TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .rst(rst), .d_in(d_in), .strobe_in(stb), .d_disp(d_disp), .valid(valid),
    .err_corr(err_corr), .err_pos(err_pos), .err_unc(err_unc), .busy(busy), .abort(abort));
  hamming_serial_rx #(.DATA_W(8), .PAR_W(4), .TIMEOUT_CYC(16)) u_dut8 (
    .clk(clk), .rst(rst), .d_in(d8), .strobe_in(stb8), .d_disp(d_disp8), .valid(valid8),
    .err_corr(err_corr8), .err_pos(err_pos8), .err_unc(err_unc8), .busy(busy8), .abort(abort8));
  always @(negedge clk) begin
    vcnt  += int'(valid);
    acnt  += int'(abort);
    vcnt8 += int'(valid8);
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // leftmost bit of the literal is sent first (codeword position 1)
  task automatic send(input logic [15:0] bits, input int n, input bit wide);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      if (wide) begin d8 = bits[i]; stb8 = 1'b1; end
      else begin d_in = bits[i]; stb = 1'b1; end
      repeat (3) @(negedge clk);
      if (wide) stb8 = 1'b0; else stb = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_d_disp", 32'(d_disp), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_err_corr", 32'(err_corr), 0);
    check("rst_err_pos", 32'(err_pos), 0);
    check("rst_err_unc", 32'(err_unc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_abort", 32'(abort), 0);
    check("rst_d_disp8", 32'(d_disp8), 0);
`ifdef HAMMING_SECDED_EN
    v0 = vcnt;
    send(16'b00101101, 8, 1'b0);
    check("ded_clean_valid", 32'(vcnt - v0), 1);
    check("ded_clean_d", 32'(d_disp), 32'h7);
    check("ded_clean_corr", 32'(err_corr), 0);
    check("ded_clean_unc", 32'(err_unc), 0);
    send(16'b01100101, 8, 1'b0);
    check("ded_double_unc", 32'(err_unc), 1);
    check("ded_double_corr", 32'(err_corr), 0);
    check("ded_double_d", 32'(d_disp), 32'h7);
    send(16'b00101100, 8, 1'b0);
    check("ded_par_corr", 32'(err_corr), 1);
    check("ded_par_pos", 32'(err_pos), 0);
    check("ded_par_unc", 32'(err_unc), 0);
    check("ded_par_d", 32'(d_disp), 32'h7);
`else
    v0 = vcnt;
    send(16'b0010110, 7, 1'b0);
    check("clean_valid", 32'(vcnt - v0), 1);
    check("clean_d", 32'(d_disp), 32'h7);
    check("clean_corr", 32'(err_corr), 0);
    check("clean_pos", 32'(err_pos), 0);
    check("clean_unc", 32'(err_unc), 0);
    check("clean_busy", 32'(busy), 0);
    for (int k = 1; k <= 7; k++) begin
      send(16'b0010110 ^ (16'd1 << (7 - k)), 7, 1'b0);
      check($sformatf("flip%0d_d", k), 32'(d_disp), 32'h7);
      check($sformatf("flip%0d_corr", k), 32'(err_corr), 1);
      check($sformatf("flip%0d_pos", k), 32'(err_pos), 32'(k));
      check($sformatf("flip%0d_unc", k), 32'(err_unc), 0);
    end
    v0 = vcnt8;
    send(16'b111100010001, 12, 1'b1);
    check("w_clean_valid", 32'(vcnt8 - v0), 1);
    check("w_clean_d", 32'(d_disp8), 32'h81);
    check("w_clean_pos", 32'(err_pos8), 0);
    v0 = vcnt8;
    send(16'b011100010000, 12, 1'b1);
    check("w_unc_valid", 32'(vcnt8 - v0), 1);
    check("w_unc_flag", 32'(err_unc8), 1);
    check("w_unc_corr", 32'(err_corr8), 0);
    check("w_unc_pos", 32'(err_pos8), 13);
    check("w_unc_d", 32'(d_disp8), 32'h81);
    a0 = acnt;
    send(16'b111, 3, 1'b0);
    check("tmo_busy", 32'(busy), 1);
    repeat (20) @(negedge clk);
    check("tmo_abort", 32'(acnt - a0), 1);
    check("tmo_busy_after", 32'(busy), 0);
    check("tmo_d_kept", 32'(d_disp), 32'h7);
    v0 = vcnt;
    send(16'b0010110, 7, 1'b0);
    check("tmo_frame_valid", 32'(vcnt - v0), 1);
    check("tmo_frame_d", 32'(d_disp), 32'h7);
    check("tmo_frame_corr", 32'(err_corr), 0);
    a0 = acnt;
    send(16'b1111, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_d", 32'(d_disp), 0);
    v0 = vcnt;
    send(16'b0010110, 7, 1'b0);
    repeat (20) @(negedge clk);
    check("mid_rst_valid", 32'(vcnt - v0), 1);
    check("mid_rst_frame_d", 32'(d_disp), 32'h7);
    check("mid_rst_no_abort", 32'(acnt - a0), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hamming_serial_rx.md
Name: hamming_serial_rx

Overview:
- Parametrised serial Hamming receiver; generalises the 4-bit strobe-fed error-correcting display block.
- Shifts in one codeword bit per `strobe_in` rising edge and corrects single-bit errors.
- Registers the corrected data for the display path and reports error status.
- Adds a clock domain, frame timeout/abort and an uncorrectable-syndrome flag.

Parameters:
- DATA_W, 4: data bits per codeword.
- PAR_W, 3: Hamming parity bits. Requires 2^PAR_W >= DATA_W+PAR_W+1. N = DATA_W+PAR_W.
- TIMEOUT_CYC, 1024: idle clk cycles mid-frame before the partial frame is discarded. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- d_in  in  1  serial codeword bit; stable around the strobe rising edge.
- strobe_in  in  1  asynchronous bit strobe (button or bench); min 2 clk high and 2 clk low.
- d_disp  out  DATA_W  last corrected data word.
- valid  out  1  one-cycle pulse when a frame is decoded.
- err_corr  out  1  a single error was corrected in the last frame.
- err_pos  out  PAR_W  syndrome of the last frame (bit position flipped; 0 = none).
- err_unc  out  1  last frame was uncorrectable; d_disp not updated.
- busy  out  1  partial frame in progress (bit_cnt != 0).
- abort  out  1  one-cycle pulse when a partial frame is dropped by timeout.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - d_disp=0, valid=0, err_corr=0, err_pos=0, err_unc=0, busy=0, abort=0.
  - Synchroniser flops cleared, bit_cnt=0, timeout counter=0, state=COLLECT.
  - A reset mid-frame discards the partial frame with no abort pulse.
- Input path:
  - strobe_in and d_in each pass through 2 sync flops, then a 3rd flop on the strobe.
  - edge = s2 & ~s3. The bit captured is the synced d_in aligned with s2.
- Framing:
  - The first bit after idle/decode is codeword position 1; the Nth bit is position N.
  - Stored in cw[1..N].
- Data mapping: data bits occupy the non-power-of-two positions in ascending order. d_disp[0] = lowest such position; for (7,4), positions 3,5,6,7 map to d[0..3].
- FSM:
  - COLLECT: on edge, store the bit at cw[bit_cnt+1] and increment bit_cnt. On the edge that stores bit N, go to DECODE and clear bit_cnt.
  - DECODE (1 cycle):
    - syndrome = XOR of the indices of all set cw bits.
    - syndrome == 0: clean, err_corr=0.
    - 1 <= syndrome <= N: flip cw[syndrome], err_corr=1.
    - syndrome > N: err_unc=1 and d_disp held.
    - In every case err_pos=syndrome, status is registered and valid=1 on the following cycle. Then return to COLLECT.
  - An edge arriving in the DECODE cycle is stored as bit 1 of the next frame; no bit is lost.
- Latency: valid rises 2 clk after the clk in which the final edge is detected (≈4–5 clk after the strobe_in rise).
- Status outputs (err_corr, err_pos, err_unc) hold until the next valid.
- Timeout:
  - The counter clears on every edge and counts while busy.
  - On reaching TIMEOUT_CYC: bit_cnt=0, abort pulses 1 cycle, d_disp and status are unchanged.
  - An edge in the same cycle as the timeout wins: the bit is stored and there is no abort.
- Simultaneous rst and edge: rst wins.

Optional Feature:
- Macro: HAMMING_SECDED_EN.
- Defined:
  - Frame length is N+1; bit N+1 is overall even parity over cw[1..N].
  - Overall mismatch: single error. Correct per syndrome; syndrome 0 means the parity bit itself was wrong, so err_corr=1, err_pos=0.
  - Overall match with syndrome != 0: double error. err_unc=1, d_disp held.
- Undefined: plain SEC as above. Frame length N.

Test Plan:
- Clean (7,4), bits 0,0,1,0,1,1,0 → valid pulse, d_disp=4'h7, err_corr=0, err_pos=0, err_unc=0.
- Bit 1 flipped, bits 1,0,1,0,1,1,0 → d_disp=4'h7, err_corr=1, err_pos=1.
- Position 7 flipped, bits 0,0,1,0,1,1,1 → d_disp=4'h7, err_pos=7; repeat with each of positions 1–7 flipped → d_disp always 4'h7.
- DATA_W=8, PAR_W=4: frame with syndrome 13 → err_unc=1, d_disp keeps its previous value, valid pulses.
- Timeout, TIMEOUT_CYC=16: send 3 bits, idle 20 clk → one abort pulse, busy=0; then a clean 7-bit frame → d_disp=4'h7. Separately, rst after 4 bits then a clean frame → correct decode, no abort.
- HAMMING_SECDED_EN: clean 8-bit frame 0,0,1,0,1,1,0,1 → 4'h7; flip bits 2 and 5 → err_unc=1, d_disp held; flip only bit 8 → err_corr=1, err_pos=0, d_disp=4'h7.
